// File: rtl/rtc_bus_sequencer.sv
// Single-transaction master for the RTC's multiplexed address/data bus: one address
// cycle, then one write- or read-data cycle. Every pin is a flop decoded from the next state.
module rtc_bus_sequencer #(
    parameter int unsigned T_PH = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       AD,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SET,
        S_A_STB,
        S_A_HLD,
        S_GAP,
        S_D_SET,
        S_D_STB,
        S_D_HLD,
        S_DONE
    } state_e;

    localparam logic [7:0] PH_LOAD = 8'(T_PH - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic       ad_q, ad_d;
    logic       cs_q, cs_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       oe_q, oe_d;
    logic [7:0] bus_out_q, bus_out_d;
    logic [7:0] rdata_q, rdata_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       phase_end;

    assign phase_end = (cnt_q == 8'd0);

    // NOTE: every variable gets its default before the case; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = S_A_SET;
                end
            end
            S_A_SET: if (phase_end) state_d = S_A_STB;
            S_A_STB: if (phase_end) state_d = S_A_HLD;
            S_A_HLD: if (phase_end) state_d = S_GAP;
            S_GAP:   if (phase_end) state_d = S_D_SET;
            S_D_SET: if (phase_end) state_d = S_D_STB;
            S_D_STB: if (phase_end) state_d = S_D_HLD;
            S_D_HLD: if (phase_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Counter reloads on entry to each timed state and stops at zero, so T_PH=1 never wraps.
        if (state_d != state_q) begin
            cnt_d = (state_d == S_IDLE || state_d == S_DONE) ? 8'd0 : PH_LOAD;
        end else if (!phase_end) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Pins are decoded from the state being entered so they change on the same edge as the state.
    always_comb begin
        ad_d      = 1'b1;
        cs_d      = 1'b1;
        rd_d      = 1'b1;
        wr_d      = 1'b1;
        oe_d      = 1'b0;
        bus_out_d = bus_out_q;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        rdata_d   = rdata_q;

        unique case (state_d)
            S_A_SET, S_A_HLD: begin
                ad_d      = 1'b0;
                cs_d      = 1'b0;
                oe_d      = 1'b1;
                bus_out_d = addr_d;
            end
            S_A_STB: begin
                ad_d      = 1'b0;
                cs_d      = 1'b0;
                oe_d      = 1'b1;
                wr_d      = 1'b0;
                bus_out_d = addr_d;
            end
            S_D_SET, S_D_HLD: begin
                cs_d = 1'b0;
                if (!rw_d) begin
                    oe_d      = 1'b1;
                    bus_out_d = wdata_d;
                end
            end
            S_D_STB: begin
                cs_d = 1'b0;
                if (rw_d) begin
                    rd_d = 1'b0;
                end else begin
                    oe_d      = 1'b1;
                    wr_d      = 1'b0;
                    bus_out_d = wdata_d;
                end
            end
            default: ;
        endcase

        // Capture the read byte at the edge that closes the strobe.
        if (state_q == S_D_STB && phase_end && rw_q) begin
            rdata_d = bus_in;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            rw_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            ad_q      <= 1'b1;
            cs_q      <= 1'b1;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            oe_q      <= 1'b0;
            bus_out_q <= 8'h00;
            rdata_q   <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ad_q      <= ad_d;
            cs_q      <= cs_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            oe_q      <= oe_d;
            bus_out_q <= bus_out_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus_out = bus_out_q;
    assign bus_oe  = oe_q;
    assign AD      = ad_q;
    assign CS      = cs_q;
    assign RD      = rd_q;
    assign WR      = wr_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: unit 0 runs T_PH=2, unit 1 runs T_PH=1. Each cycle of every
// transaction is compared with a phase-index model of the bus waveform.
module tb_rtc_bus_sequencer;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [1:0]      reset_v, start_v, rw_v;
    logic [1:0][7:0] addr_v, wdata_v, bus_in_v;
    logic [1:0][7:0] bus_out_v, rdata_v;
    logic [1:0]      oe_v, ad_v, cs_v, rd_v, wr_v, busy_v, done_v;

    logic [1:0][7:0] exp_bo, exp_rd;
    int checks = 0;
    int errors = 0;

    rtc_bus_sequencer #(.T_PH(2)) u_dut2 (
        .Clk(Clk), .Reset(reset_v[0]), .start(start_v[0]), .rw(rw_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .bus_in(bus_in_v[0]),
        .bus_out(bus_out_v[0]), .bus_oe(oe_v[0]), .AD(ad_v[0]), .CS(cs_v[0]),
        .RD(rd_v[0]), .WR(wr_v[0]), .rdata(rdata_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    rtc_bus_sequencer #(.T_PH(1)) u_dut1 (
        .Clk(Clk), .Reset(reset_v[1]), .start(start_v[1]), .rw(rw_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .bus_in(bus_in_v[1]),
        .bus_out(bus_out_v[1]), .bus_oe(oe_v[1]), .AD(ad_v[1]), .CS(cs_v[1]),
        .RD(rd_v[1]), .WR(wr_v[1]), .rdata(rdata_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Packed view {AD,CS,RD,WR,OE,BUSY,DONE,BUS_OUT,RDATA}
    function automatic logic [22:0] pins(input logic ad, cs, rd, wr, oe, bsy, dn,
                                         input logic [7:0] bo, rdt);
        return {ad, cs, rd, wr, oe, bsy, dn, bo, rdt};
    endfunction

    function automatic logic [22:0] actual(input int u);
        return pins(ad_v[u], cs_v[u], rd_v[u], wr_v[u], oe_v[u], busy_v[u], done_v[u],
                    bus_out_v[u], rdata_v[u]);
    endfunction

    // Cycle j counts from the cycle right after the start edge. Phases 0-2 address,
    // 3 gap, 4-6 data (5 is the strobe); cycle 7*tph is the done cycle.
    function automatic logic [22:0] model(input int tph, input int j, input bit rw,
                                          input logic [7:0] a, w, bin, old_rd);
        int p;
        logic ad, cs, rd, wr, oe, bsy, dn;
        logic [7:0] bo, rdt;
        p   = j / tph;
        ad  = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1; oe = 1'b0; bsy = 1'b0; dn = 1'b0;
        bo  = rw ? a : w;
        if (j < 7 * tph) begin
            bsy = 1'b1;
            ad  = !(p <= 2);
            cs  = (p == 3);
            wr  = !(p == 1 || (p == 5 && !rw));
            rd  = !(p == 5 && rw);
            oe  = (p <= 2) || (p >= 4 && !rw);
            bo  = (p >= 4 && !rw) ? w : a;
        end else begin
            bsy = (j == 7 * tph);
            dn  = (j == 7 * tph);
        end
        rdt = (rw && j >= 6 * tph) ? bin : old_rd;
        return pins(ad, cs, rd, wr, oe, bsy, dn, bo, rdt);
    endfunction

    task automatic check_idle(input int u, input string tag);
        check(tag, actual(u), pins(1, 1, 1, 1, 0, 0, 0, exp_bo[u], exp_rd[u]));
    endtask

    task automatic launch(input int u, input bit rw, input logic [7:0] a, w, bin);
        start_v[u]  = 1'b1;
        rw_v[u]     = rw;
        addr_v[u]   = a;
        wdata_v[u]  = w;
        bus_in_v[u] = ~bin;
    endtask

    // Called at the negedge where launch() set the inputs; checks each following cycle.
    task automatic follow(input int u, input int tph, input bit rw, input logic [7:0] a, w, bin,
                          input int glitch, input int abort_at, input bit hold, input string tag);
        logic [7:0] old_rd;
        int last;
        old_rd = exp_rd[u];
        last   = hold ? 7 * tph + 1 : 7 * tph + 3;
        for (int j = 0; j <= last; j++) begin
            @(negedge Clk);
            if (j == 0) begin
                if (!hold) start_v[u] = 1'b0;
                addr_v[u]  = ~a;
                wdata_v[u] = ~w;
                rw_v[u]    = ~rw;
            end
            if (glitch > 0 && j == glitch) begin
                start_v[u] = 1'b1;
                addr_v[u]  = 8'h55;
                wdata_v[u] = 8'h55;
            end
            if (glitch > 0 && j == glitch + 1) start_v[u] = 1'b0;
            bus_in_v[u] = (j == 6 * tph - 1) ? bin : ~bin;
            check($sformatf("%s cyc%0d pins", tag, j), actual(u), model(tph, j, rw, a, w, bin, old_rd));
            if (j == abort_at) begin
                reset_v[u] = 1'b1;
                exp_bo[u]  = 8'h00;
                exp_rd[u]  = 8'h00;
                @(negedge Clk);
                check_idle(u, $sformatf("%s reset_next", tag));
                reset_v[u] = 1'b0;
                for (int k = 0; k < 7 * tph + 3; k++) begin
                    @(negedge Clk);
                    check_idle(u, $sformatf("%s after_reset%0d", tag, k));
                end
                return;
            end
        end
        exp_bo[u] = rw ? a : w;
        if (rw) exp_rd[u] = bin;
    endtask

    // Protocol monitors: strobe exclusion and driver turnaround.
    always @(negedge Clk) begin
        for (int u = 0; u < 2; u++) begin
            if (reset_v[u] === 1'b0) begin
                checks += 3;
                if (rd_v[u] === 1'b0 && wr_v[u] === 1'b0) begin
                    errors++;
                    $display("FAIL strobe_overlap u%0d: RD=0 WR=0, required never both low", u);
                end
                if (oe_v[u] === 1'b1 && rd_v[u] === 1'b0) begin
                    errors++;
                    $display("FAIL turnaround u%0d: bus_oe=1 with RD=0, required bus_oe=0", u);
                end
                if (cs_v[u] === 1'b1 && (rd_v[u] === 1'b0 || wr_v[u] === 1'b0)) begin
                    errors++;
                    $display("FAIL strobe_no_cs u%0d: strobe low with CS=1, required strobes high", u);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         rw;
        logic [7:0] a;
        logic [7:0] w;
        logic [7:0] bin;
        logic [7:0] exp_rdata;
        logic [7:0] exp_bus_out;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{rw: 1'b0, a: 8'h21, w: 8'h59, bin: 8'hE4, exp_rdata: 8'h00, exp_bus_out: 8'h59};
        vecs[1] = '{rw: 1'b1, a: 8'h22, w: 8'h00, bin: 8'h37, exp_rdata: 8'h37, exp_bus_out: 8'h22};
        vecs[2] = '{rw: 1'b0, a: 8'h00, w: 8'h00, bin: 8'hFF, exp_rdata: 8'h37, exp_bus_out: 8'h00};
        vecs[3] = '{rw: 1'b1, a: 8'h7F, w: 8'h12, bin: 8'hA5, exp_rdata: 8'hA5, exp_bus_out: 8'h7F};
        vecs[4] = '{rw: 1'b1, a: 8'h00, w: 8'h34, bin: 8'h00, exp_rdata: 8'h00, exp_bus_out: 8'h00};
        vecs[5] = '{rw: 1'b0, a: 8'hFF, w: 8'hFF, bin: 8'h5A, exp_rdata: 8'h00, exp_bus_out: 8'hFF};

        reset_v  = 2'b11;
        start_v  = 2'b11;
        rw_v     = 2'b00;
        addr_v   = '0;
        wdata_v  = '0;
        bus_in_v = '0;
        exp_bo   = '0;
        exp_rd   = '0;

        // Reset held for 3 cycles with start asserted
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            check_idle(0, $sformatf("reset_hold u0 c%0d", c));
            check_idle(1, $sformatf("reset_hold u1 c%0d", c));
        end
        reset_v = 2'b00;
        start_v = 2'b00;
        @(negedge Clk);
        check_idle(0, "post_reset u0");
        check_idle(1, "post_reset u1");

        // Table-driven transactions on T_PH=2
        foreach (vecs[i]) begin
            @(negedge Clk);
            launch(0, vecs[i].rw, vecs[i].a, vecs[i].w, vecs[i].bin);
            follow(0, 2, vecs[i].rw, vecs[i].a, vecs[i].w, vecs[i].bin, -1, -1, 1'b0,
                   $sformatf("vec%0d", i));
            check($sformatf("vec%0d rdata", i), rdata_v[0], vecs[i].exp_rdata);
            check($sformatf("vec%0d bus_out_hold", i), bus_out_v[0], vecs[i].exp_bus_out);
        end

        // Start pulses while busy (mid-address and during DONE) are ignored
        @(negedge Clk);
        launch(0, 1'b0, 8'h10, 8'hC3, 8'h00);
        follow(0, 2, 1'b0, 8'h10, 8'hC3, 8'h00, 5, -1, 1'b0, "busy_start_mid");
        @(negedge Clk);
        launch(0, 1'b1, 8'h2A, 8'h00, 8'h81);
        follow(0, 2, 1'b1, 8'h2A, 8'h00, 8'h81, 14, -1, 1'b0, "busy_start_done");

        // Reset in the first cycle of read D_STB
        @(negedge Clk);
        launch(0, 1'b1, 8'h40, 8'h00, 8'h6C);
        follow(0, 2, 1'b1, 8'h40, 8'h00, 8'h6C, -1, -1, 1'b0, "pre_abort_read");
        @(negedge Clk);
        launch(0, 1'b1, 8'h33, 8'h00, 8'h99);
        follow(0, 2, 1'b1, 8'h33, 8'h00, 8'h99, -1, 10, 1'b0, "abort_read");

        // T_PH=1 with start held high: a launch every 9 cycles, inputs re-latched each time
        @(negedge Clk);
        for (int n = 0; n < 6; n++) begin
            bit rw;
            logic [7:0] a, w, bin;
            rw  = 1'($urandom_range(0, 1));
            a   = 8'($urandom);
            w   = 8'($urandom);
            bin = 8'($urandom);
            launch(1, rw, a, w, bin);
            follow(1, 1, rw, a, w, bin, -1, -1, 1'b1, $sformatf("b2b%0d", n));
        end
        start_v[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            check_idle(1, $sformatf("b2b_tail c%0d", c));
        end

        // Randomized transactions on both units
        for (int i = 0; i < 24; i++) begin
            int u;
            bit rw;
            logic [7:0] a, w, bin;
            u   = i % 2;
            rw  = 1'($urandom_range(0, 1));
            a   = 8'($urandom);
            w   = 8'($urandom);
            bin = 8'($urandom);
            @(negedge Clk);
            launch(u, rw, a, w, bin);
            follow(u, (u == 0) ? 2 : 1, rw, a, w, bin, -1, -1, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Single-transaction master for the multiplexed address/data bus of the real-time clock chip. It sits between the PicoBlaze output/input port registers and the `Data_Bus` pad. On one start pulse it runs a complete address cycle followed by either a write-data or a read-data cycle, with registered, glitch-free strobes. It reports completion with a one-cycle `done` pulse and holds the read byte in `rdata` for the processor's input-port mux.

## Interface
- `T_PH`, default 5: clock cycles per bus phase (legal range 1..255); 5 gives 50 ns per phase at 100 MHz.
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  transaction request; sampled only in IDLE.
- `rw`  in  1  transaction type: 1 = read, 0 = write; latched at start.
- `addr`  in  8  RTC register address; latched at start.
- `wdata`  in  8  write data; latched at start.
- `bus_in`  in  8  pad input side of `Data_Bus`.
- `bus_out`  out  8  pad output side of `Data_Bus`.
- `bus_oe`  out  1  pad driver enable; 1 = drive `bus_out`.
- `AD`  out  1  address/data select; 0 = address phase.
- `CS`  out  1  chip select, active-low.
- `RD`  out  1  read strobe, active-low.
- `WR`  out  1  write strobe, active-low.
- `rdata`  out  8  last byte read.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **Registered outputs:** all outputs are registered and are decoded from the state register. No combinational path runs from the inputs to the pins.
- **States:** IDLE, A_SET, A_STB, A_HLD, GAP, D_SET, D_STB, D_HLD, DONE.
- **State timing:** each state from A_SET through D_HLD lasts exactly T_PH cycles, counted by an 8-bit phase counter that reloads on every state change. IDLE and DONE each last 1 cycle.
- **IDLE:** AD=1, CS=1, RD=1, WR=1, bus_oe=0, busy=0.
- **Start:** `start` = 1 in IDLE latches `rw`, `addr` and `wdata`, then moves to A_SET. `start` is ignored in every other state, with no queueing.
- **Address phase:**
  - A_SET: AD=0, CS=0, bus_oe=1, bus_out=addr.
  - A_STB: as A_SET, plus WR=0.
  - A_HLD: as A_SET, WR=1.
- **GAP:** AD=1, CS=1, RD=1, WR=1, bus_oe=0.
- **Write data phase (`rw` = 0):**
  - D_SET: AD=1, CS=0, bus_oe=1, bus_out=wdata.
  - D_STB: as D_SET, plus WR=0.
  - D_HLD: as D_SET, WR=1.
- **Read data phase (`rw` = 1):**
  - D_SET: AD=1, CS=0, bus_oe=0.
  - D_STB: as D_SET, plus RD=0. `rdata` loads `bus_in` on the last cycle of D_STB.
  - D_HLD: as D_SET, RD=1.
- **DONE:** pin outputs as in IDLE, done=1, busy=1. The next state is always IDLE.
- **Strobe mutual exclusion:** RD and WR are never low together. Neither strobe is low while CS=1.
- **Driver turnaround:** `bus_oe` is never 1 in the same cycle that RD=0.
- **`bus_out` when not driven:** holds the last driven value while `bus_oe` = 0.
- **`rdata` retention:** unchanged by write transactions and by IDLE. It updates only on read completion.

## Timing
- **Reset values:** AD=1, CS=1, RD=1, WR=1, bus_oe=0, bus_out=0x00, rdata=0x00, busy=0, done=0. State is IDLE and the counter is 0.
- **Start latency:** if `start` is sampled at edge k, then A_SET pin values are visible after edge k and busy=1 from that cycle.
- **Done latency:** done=1 in the cycle following edge k+7·T_PH. busy drops one cycle later.
- **Back-to-back transactions:** minimum spacing is one IDLE cycle between DONE and the next A_SET. Start-to-start is therefore 7·T_PH+2 cycles.
- **`rdata` validity:** `rdata` is valid from the cycle done=1 is asserted, and is stable until the next read's D_STB sample.
- **Reset mid-transaction:** all outputs take reset values on the next edge and no done pulse occurs. `rdata` is cleared.
- **T_PH=1:** each phase is a single cycle with identical ordering. The counter never underflows.
- **`start` held high:** a continuously asserted `start` launches a new transaction every 7·T_PH+2 cycles. Inputs are re-latched at each launch.

## Test plan
- **Reset:** hold Reset for 3 cycles with `start`=1 → all outputs at reset values, busy=0, no strobe activity.
- **Write:** T_PH=2, write addr=0x21 wdata=0x59 → AD low for 6 cycles with bus_out=0x21 and WR low during cycles 3-4. Then 2 GAP cycles. Then CS low for 6 cycles with bus_out=0x59 and WR low during cycles 3-4. done arrives 14 cycles after the start edge.
- **Read:** T_PH=2, read addr=0x22 with bus_in=0x37 → bus_oe=0 throughout the data phase and RD low for 2 cycles. `rdata`=0x37 when done=1 and remains 0x37 after a following write of 0x00.
- **Start while busy:** pulse `start` with addr=0x55 mid-transaction → ignored. The bus shows only the original address, and exactly one done pulse occurs.
- **Reset mid-transaction:** assert Reset during read D_STB → next cycle RD=1, CS=1, bus_oe=0, rdata=0x00, and no done pulse.
- **T_PH=1 back-to-back:** `start` held high → done pulses every 9 cycles. RD and WR are never low simultaneously, and bus_oe is never 1 while RD=0; both are checked by assertions.
